// File: rtl/regfile_link_ctl.sv
// regfile_link_ctl: parametrised register file (2 async read ports, 1 write port) with an IRQ
// link-capture path and one-entry pending buffer. Define REGFILE_BYPASS_EN for same-cycle forwarding.
module regfile_link_ctl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = 2**ADDR_W - 1,
    parameter int LINK_OFFSET = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic              wr_c,
    input  logic [DATA_W-1:0] wdata_c,
    input  logic [DATA_W-1:0] pc,
    input  logic              irq,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              link_pending,
    output logic              link_taken
);

    localparam int                NREG      = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [DATA_W-2:0] LINK_OFS  = (DATA_W-1)'(LINK_OFFSET);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [NREG-1:0]   valid_q, valid_d;
    logic              irq_q;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pend_val_q, pend_val_d;
    logic              taken_q, taken_d;

    logic              capture, port_we, blocked, link_src, link_we;
    logic [DATA_W-1:0] link_val, link_wdata;

    // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        capture    = irq & ~irq_q & ~pc[DATA_W-1];
        link_val   = {pc[DATA_W-1], pc[DATA_W-2:0] + LINK_OFS};
        link_src   = capture | pend_q;
        link_wdata = capture ? link_val : pend_val_q;
        port_we    = wr_c && (addr_c != '0);
        blocked    = wr_c && (addr_c == LINK_ADDR);
        link_we    = link_src & ~blocked;
        pend_d     = link_src & blocked;
        pend_val_d = pend_d ? link_wdata : pend_val_q;
        taken_d    = link_we;
        valid_d    = valid_q;
        if (port_we) valid_d[addr_c] = 1'b1;
        if (link_we) valid_d[LINK_ADDR] = 1'b1;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] rd;
        rd = valid_q[addr] ? mem_q[addr] : '0;
`ifdef REGFILE_BYPASS_EN
        if (port_we && addr == addr_c) rd = wdata_c;
        else if (link_we && addr == LINK_ADDR) rd = link_wdata;
`endif
        if (addr == '0) rd = '0;
        return rd;
    endfunction

    always_comb begin
        rdata_a = read_port(addr_a);
        rdata_b = read_port(addr_b);
    end

    // NOTE: the data array is deliberately not reset; the valid bitmap masks stale contents,
    // which is what lets reset clear the whole file in one cycle.
    always_ff @(posedge clk) begin
        if (port_we) mem_q[addr_c] <= wdata_c;
        if (link_we) mem_q[LINK_ADDR] <= link_wdata;
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            irq_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            taken_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            irq_q      <= irq;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            taken_q    <= taken_d;
        end
    end

    assign link_pending = pend_q;
    assign link_taken   = taken_q;

endmodule

// File: tb/tb_regfile_link_ctl.sv
// Self-checking bench for regfile_link_ctl: a register model feeds a scoreboard of expected reads,
// popped and compared on port A; flag and port-B checks are inline in each scenario task.
module tb_regfile_link_ctl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  addr_a = '0, addr_b = '0, addr_c = '0;
    logic        wr_c = 1'b0;
    logic [31:0] wdata_c = '0, pc = '0;
    logic        irq = 1'b0;
    logic [31:0] rdata_a, rdata_b;
    logic        link_pending, link_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];

    always #10 clk = ~clk;

    regfile_link_ctl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .addr_c      (addr_c),
        .wr_c        (wr_c),
        .wdata_c     (wdata_c),
        .pc          (pc),
        .irq         (irq),
        .rdata_a     (rdata_a),
        .rdata_b     (rdata_b),
        .link_pending(link_pending),
        .link_taken  (link_taken)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic expect_reg(input string name, input logic [4:0] a);
        exp_t e;
        e.name = name;
        e.addr = a;
        e.data = (a == 5'd0) ? 32'h0 : model[a];
        exp_q.push_back(e);
    endtask

    task automatic expect_val(input string name, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.name = name;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        #1;
        model_clear();
        expect_reg("rst_r0", 5'd0);
        expect_reg("rst_r5", 5'd5);
        expect_reg("rst_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        checks++;
        if (link_pending !== 1'b0 || link_taken !== 1'b0) begin
            errors++; $display("FAIL rst_flags: pending=%b taken=%b expected 0 0", link_pending, link_taken);
        end
        @(negedge clk) reset_n = 1'b1;
        step();
        wr_c = 1'b1; addr_c = 5'd5; wdata_c = 32'hDEADBEEF;
        step();
        wr_c = 1'b0;
        model[5] = 32'hDEADBEEF;
        expect_reg("wr_r5", 5'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        expect_reg("async_rst_r5", 5'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        @(negedge clk) reset_n = 1'b1;
        step();
        wr_c = 1'b1; addr_c = 5'd5; wdata_c = 32'h12;
        step();
        wr_c = 1'b0;
        model[5] = 32'h12;
        expect_reg("post_rst_r5", 5'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
    endtask

    task automatic test_r0_write();
        exp_t e;
        wr_c = 1'b1; addr_c = 5'd3; wdata_c = 32'h33;
        step();
        model[3] = 32'h33;
        addr_c = 5'd0; wdata_c = 32'hFFFFFFFF;
        step();
        wr_c = 1'b0;
        expect_reg("r0_zero", 5'd0);
        expect_reg("r0_keep_r3", 5'd3);
        expect_reg("r0_keep_r5", 5'd5);
        expect_reg("r0_keep_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
    endtask

    task automatic test_link_capture();
        exp_t e;
        irq = 1'b0; pc = 32'h00400010;
        step();
        irq = 1'b1;
        step();
        checks++;
        if (link_taken !== 1'b1 || link_pending !== 1'b0) begin
            errors++; $display("FAIL cap_flags: taken=%b pending=%b expected 1 0", link_taken, link_pending);
        end
        model[31] = 32'h00400014;
        expect_reg("cap_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        pc = 32'h00500000;
        step();
        checks++;
        if (link_taken !== 1'b0) begin errors++; $display("FAIL cap_pulse: taken=%b expected 0", link_taken); end
        step();
        expect_reg("cap_held_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        irq = 1'b0;
    endtask

    task automatic test_collision();
        exp_t e;
        irq = 1'b0;
        step();
        pc = 32'h00400100; irq = 1'b1;
        wr_c = 1'b1; addr_c = 5'd31; wdata_c = 32'hAA;
        step();
        wr_c = 1'b0;
        checks++;
        if (link_pending !== 1'b1 || link_taken !== 1'b0) begin
            errors++; $display("FAIL col_block: pending=%b taken=%b expected 1 0", link_pending, link_taken);
        end
`ifdef REGFILE_BYPASS_EN
        expect_val("col_r31_fwd", 5'd31, 32'h00400104);
`else
        expect_val("col_r31_port", 5'd31, 32'hAA);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        step();
        checks++;
        if (link_pending !== 1'b0 || link_taken !== 1'b1) begin
            errors++; $display("FAIL col_retire: pending=%b taken=%b expected 0 1", link_pending, link_taken);
        end
        model[31] = 32'h00400104;
        expect_reg("col_r31_link", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        step();
        checks++;
        if (link_taken !== 1'b0) begin errors++; $display("FAIL col_pulse: taken=%b expected 0", link_taken); end
        irq = 1'b0;
    endtask

    task automatic test_replace_and_kernel_retire();
        exp_t e;
        irq = 1'b0;
        step();
        pc = 32'h00001000; irq = 1'b1;
        wr_c = 1'b1; addr_c = 5'd31; wdata_c = 32'hBB;
        step();
        irq = 1'b0;
        step();
        pc = 32'h00002000; irq = 1'b1;
        step();
        checks++;
        if (link_pending !== 1'b1 || link_taken !== 1'b0) begin
            errors++; $display("FAIL rep_hold: pending=%b taken=%b expected 1 0", link_pending, link_taken);
        end
        wr_c = 1'b0;
        step();
        checks++;
        if (link_pending !== 1'b0 || link_taken !== 1'b1) begin
            errors++; $display("FAIL rep_retire: pending=%b taken=%b expected 0 1", link_pending, link_taken);
        end
        model[31] = 32'h00002004;
        expect_reg("rep_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        irq = 1'b0;
        step();
        pc = 32'h00003000; irq = 1'b1;
        wr_c = 1'b1; addr_c = 5'd31; wdata_c = 32'hCC;
        step();
        irq = 1'b0;
        step();
        pc = 32'h80004000; irq = 1'b1; wr_c = 1'b0;
        step();
        checks++;
        if (link_pending !== 1'b0 || link_taken !== 1'b1) begin
            errors++; $display("FAIL kern_retire: pending=%b taken=%b expected 0 1", link_pending, link_taken);
        end
        model[31] = 32'h00003004;
        expect_reg("kern_retire_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        irq = 1'b0;
    endtask

    task automatic test_kernel_and_wrap();
        exp_t e;
        irq = 1'b0;
        step();
        pc = 32'h80001000; irq = 1'b1;
        step();
        step();
        checks++;
        if (link_pending !== 1'b0 || link_taken !== 1'b0) begin
            errors++; $display("FAIL kern_ignore: pending=%b taken=%b expected 0 0", link_pending, link_taken);
        end
        expect_reg("kern_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        irq = 1'b0;
        step();
        pc = 32'h7FFFFFFC; irq = 1'b1;
        step();
        checks++;
        if (link_taken !== 1'b1) begin errors++; $display("FAIL wrap_taken: taken=%b expected 1", link_taken); end
        model[31] = 32'h00000000;
        expect_reg("wrap_r31", 5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        irq = 1'b0;
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        wr_c = 1'b1; addr_c = 5'd7; wdata_c = 32'h11;
        step();
        model[7] = 32'h11;
        wdata_c = 32'h55; addr_b = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h55;
`else
        want = model[7];
`endif
        checks++;
        if (rdata_b !== want) begin errors++; $display("FAIL byp_same: rdata_b=%h expected %h", rdata_b, want); end
        step();
        wr_c = 1'b0;
        model[7] = 32'h55;
        checks++;
        if (rdata_b !== model[7]) begin errors++; $display("FAIL byp_after: rdata_b=%h expected %h", rdata_b, model[7]); end
        wr_c = 1'b1; addr_c = 5'd0; wdata_c = 32'h77; addr_b = 5'd0;
        #1;
        checks++;
        if (rdata_b !== 32'h0) begin errors++; $display("FAIL byp_r0: rdata_b=%h expected 0", rdata_b); end
        step();
        wr_c = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        irq = 1'b0; pc = 32'h00400010;
        step();
        irq = 1'b1;
        wr_c = 1'b1; addr_c = 5'd31; wdata_c = 32'hDD;
        step();
        wr_c = 1'b0;
        checks++;
        if (link_pending !== 1'b1) begin errors++; $display("FAIL mr_setup: pending=%b expected 1", link_pending); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (link_pending !== 1'b0 || link_taken !== 1'b0) begin
            errors++; $display("FAIL mr_flags: pending=%b taken=%b expected 0 0", link_pending, link_taken);
        end
        model_clear();
        expect_reg("mr_r31", 5'd31);
        expect_reg("mr_r7", 5'd7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        @(negedge clk) reset_n = 1'b1;
        step();
        checks++;
        if (link_taken !== 1'b1 || link_pending !== 1'b0) begin
            errors++; $display("FAIL rel_rise: taken=%b pending=%b expected 1 0", link_taken, link_pending);
        end
        model[31] = 32'h00400014;
        expect_reg("rel_r31", 5'd31);
        expect_reg("rel_r7", 5'd7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); addr_a = e.addr; #1; checks++;
            if (rdata_a !== e.data) begin errors++; $display("FAIL %s: r%0d read %h expected %h", e.name, e.addr, rdata_a, e.data); end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (link_taken !== 1'b0) begin errors++; $display("FAIL mr_taken: taken=%b expected 0", link_taken); end
        irq = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        step();
        checks++;
        if (link_taken !== 1'b0 || link_pending !== 1'b0) begin
            errors++; $display("FAIL mr_idle: taken=%b pending=%b expected 0 0", link_taken, link_pending);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_r0_write();
        test_link_capture();
        test_collision();
        test_replace_and_kernel_retire();
        test_kernel_and_wrap();
        test_bypass();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
